mmio_key_port: RTL and testbench

//  Memory-mapped pushbutton peripheral on the CPU data bus (mem_addr/mem_cmd/write_data/read_data).
//  - Synchronises and debounces the raw active-low KEY inputs.
//  - Latches sticky press events and counts presses.
//  - Firmware polls it with LDR and clears it with STR, alongside the SW (9'h140) and LEDR (9'h100) ports.
//  - Addresses sit in the mem_addr[8]=1 I/O window, so they never collide with RAM.

---
 rtl/mmio_key_port_pkg.sv | 18 +
 rtl/mmio_key_port_debounce.sv | 52 +++++
 rtl/mmio_key_port.sv | 97 +++++++++
 tb/tb_mmio_key_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_key_port_pkg.sv
// Shared CPU-bus definitions: command bit positions, I/O window rule and
// the fixed addresses of the memory-mapped peripherals.
package mmio_key_port_pkg;

    localparam int MREAD_BIT  = 0;
    localparam int MWRITE_BIT = 1;

    localparam logic [8:0] LEDR_ADDR       = 9'h100;
    localparam logic [8:0] SW_ADDR         = 9'h140;
    localparam logic [8:0] KEY_STATUS_ADDR = 9'h150;
    localparam logic [8:0] KEY_COUNT_ADDR  = 9'h151;

    // Peripherals live where mem_addr[8] is set, so RAM decode never overlaps them.
    function automatic logic is_io_addr(input logic [8:0] addr);
        return addr[8];
    endfunction

endpackage

// File: rtl/mmio_key_port_debounce.sv
// One pushbutton: two-flop synchroniser, stability counter and accepted level,
// plus a single-cycle pulse on the edge where a press is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic stable_o,
    output logic press_o
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed;
    logic             at_limit;

    assign pressed  = ~sync2_q;
    assign at_limit = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (pressed != stable_q) begin
            if (at_limit) begin
                stable_d = pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = pressed & ~stable_q & at_limit;

endmodule

// File: rtl/mmio_key_port.sv
// Memory-mapped pushbutton port: debounced levels, sticky W1C press events,
// an 8-bit press counter and a tri-state read mux on the CPU data bus.
module mmio_key_port
    import mmio_key_port_pkg::*;
#(
    parameter int         N_KEYS          = 4,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         CNT_W           = 19,
    parameter logic [8:0] STATUS_ADDR     = KEY_STATUS_ADDR,
    parameter logic [8:0] COUNT_ADDR      = KEY_COUNT_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [8:0]        mem_addr,
    input  logic [1:0]        mem_cmd,
    input  logic [15:0]       write_data,
    output logic [15:0]       read_data,
    output logic              key_irq
);

    logic [N_KEYS-1:0] stable, press;
    logic [N_KEYS-1:0] events_q, events_d, clr_mask;
    logic [7:0]        press_cnt_q, press_cnt_d;
    logic              key_irq_q;
    logic              hit_status, hit_count;
    logic              wr_status, wr_count, rd_status, rd_count;
    logic [3:0]        stable4, events4;
    logic              unused_wd;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .key_n_i (key_raw[g]),
            .stable_o(stable[g]),
            .press_o (press[g])
        );
    end

    function automatic logic [7:0] count_ones(input logic [N_KEYS-1:0] v);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < N_KEYS; i++) begin
            c = c + {7'b0, v[i]};
        end
        return c;
    endfunction

    assign hit_status = is_io_addr(mem_addr) && (mem_addr == STATUS_ADDR);
    assign hit_count  = is_io_addr(mem_addr) && (mem_addr == COUNT_ADDR);
    assign wr_status  = mem_cmd[MWRITE_BIT] & hit_status;
    assign wr_count   = mem_cmd[MWRITE_BIT] & hit_count;
    assign rd_status  = mem_cmd[MREAD_BIT]  & hit_status;
    assign rd_count   = mem_cmd[MREAD_BIT]  & hit_count;

    // Presses are OR-ed in after the clear, so a same-cycle press survives a W1C.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            clr_mask[i] = wr_status & write_data[4+i];
        end
        events_d    = (events_q & ~clr_mask) | press;
        press_cnt_d = (wr_count ? 8'h00 : press_cnt_q) + count_ones(press);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            events_q    <= '0;
            press_cnt_q <= 8'h00;
            key_irq_q   <= 1'b0;
        end else begin
            events_q    <= events_d;
            press_cnt_q <= press_cnt_d;
            key_irq_q   <= |events_d;
        end
    end

    always_comb begin
        stable4 = 4'h0;
        events4 = 4'h0;
        for (int i = 0; i < N_KEYS; i++) begin
            stable4[i] = stable[i];
            events4[i] = events_q[i];
        end
    end

    assign read_data = rd_status ? {8'h00, events4, stable4} :
                       rd_count  ? {8'h00, press_cnt_q}      : 16'bz;

    assign key_irq   = key_irq_q;
    assign unused_wd = ^write_data;

endmodule

// File: tb/tb_mmio_key_port.sv
// Directed bench for mmio_key_port with a short debounce window (4 cycles).
module tb_mmio_key_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key_raw;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] write_data;
    wire  [15:0] rd_bus;
    wire         key_irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] rv;

    always #5 clk = ~clk;

    // Undriven bus floats high, so a deselected port reads 16'hFFFF here.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (rd_bus[g]);
    end

    mmio_key_port #(
        .N_KEYS         (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .STATUS_ADDR    (9'h150),
        .COUNT_ADDR     (9'h151)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_raw   (key_raw),
        .mem_addr  (mem_addr),
        .mem_cmd   (mem_cmd),
        .write_data(write_data),
        .read_data (rd_bus),
        .key_irq   (key_irq)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [8:0] addr, output logic [15:0] d);
        mem_addr = addr;
        mem_cmd  = 2'b01;
        #1;
        d        = rd_bus;
        mem_cmd  = 2'b00;
    endtask

    task automatic bus_wr(input logic [8:0] addr, input logic [15:0] d);
        mem_addr   = addr;
        write_data = d;
        mem_cmd    = 2'b10;
        @(posedge clk);
        #1;
        mem_cmd    = 2'b00;
        write_data = 16'h0000;
    endtask

    initial begin
        reset_n    = 1'b0;
        key_raw    = 4'b0000;
        mem_addr   = 9'h000;
        mem_cmd    = 2'b00;
        write_data = 16'h0000;
        tick(3);

        // Reset with all keys held
        bus_rd(9'h150, rv); check_eq("rst_status", rv, 16'h0000);
        bus_rd(9'h151, rv); check_eq("rst_count", rv, 16'h0000);
        check_eq("rst_irq", {15'b0, key_irq}, 16'h0000);
        reset_n = 1'b1;
        tick(5);
        bus_rd(9'h150, rv); check_eq("rel_before", rv, 16'h0000);
        tick(1);
        bus_rd(9'h150, rv); check_eq("rel_accept", rv, 16'h00FF);
        bus_rd(9'h151, rv); check_eq("rel_count", rv, 16'h0004);
        tick(1);
        check_eq("rel_irq", {15'b0, key_irq}, 16'h0001);

        // Release everything, clear events and counter
        key_raw = 4'b1111;
        bus_wr(9'h150, 16'h00F0);
        tick(1);
        check_eq("clr_irq", {15'b0, key_irq}, 16'h0000);
        tick(8);
        bus_wr(9'h151, 16'h0000);
        bus_rd(9'h150, rv); check_eq("idle_status", rv, 16'h0000);
        bus_rd(9'h151, rv); check_eq("idle_count", rv, 16'h0000);

        // Clean press of key0
        key_raw = 4'b1110;
        tick(5);
        bus_rd(9'h150, rv); check_eq("k0_early", rv, 16'h0000);
        tick(1);
        bus_rd(9'h150, rv); check_eq("k0_status", rv, 16'h0011);
        bus_rd(9'h150, rv); check_eq("k0_reread", rv, 16'h0011);
        bus_rd(9'h151, rv); check_eq("k0_count", rv, 16'h0001);
        tick(1);
        check_eq("k0_irq", {15'b0, key_irq}, 16'h0001);

        // Glitches on key1: 3 cycles rejected, 5 cycles accepted
        key_raw = 4'b1100;
        tick(3);
        key_raw = 4'b1110;
        tick(10);
        bus_rd(9'h150, rv); check_eq("glitch3_status", rv, 16'h0011);
        bus_rd(9'h151, rv); check_eq("glitch3_count", rv, 16'h0001);
        key_raw = 4'b1100;
        tick(5);
        key_raw = 4'b1110;
        tick(1);
        bus_rd(9'h150, rv); check_eq("pulse5_status", rv, 16'h0033);
        tick(10);
        bus_rd(9'h150, rv); check_eq("pulse5_release", rv, 16'h0031);
        bus_rd(9'h151, rv); check_eq("pulse5_count", rv, 16'h0002);

        // W1C, and W1C colliding with key2's press
        bus_wr(9'h150, 16'h0010);
        bus_rd(9'h150, rv); check_eq("w1c_bit0", rv, 16'h0021);
        key_raw = 4'b1010;
        tick(5);
        bus_wr(9'h150, 16'h0040);
        bus_rd(9'h150, rv); check_eq("w1c_vs_press", rv, 16'h0065);
        bus_rd(9'h151, rv); check_eq("w1c_count", rv, 16'h0003);

        // Counter wrap after 256 presses of key3
        bus_wr(9'h151, 16'h0000);
        bus_rd(9'h151, rv); check_eq("cnt_cleared", rv, 16'h0000);
        for (int i = 0; i < 255; i++) begin
            key_raw[3] = 1'b0;
            tick(6);
            key_raw[3] = 1'b1;
            tick(6);
        end
        bus_rd(9'h151, rv); check_eq("cnt_255", rv, 16'h00FF);
        key_raw[3] = 1'b0;
        tick(6);
        key_raw[3] = 1'b1;
        tick(6);
        bus_rd(9'h151, rv); check_eq("cnt_wrap", rv, 16'h0000);

        // Counter clear on the same edge as a press
        key_raw[3] = 1'b0;
        tick(5);
        bus_wr(9'h151, 16'hBEEF);
        bus_rd(9'h151, rv); check_eq("clr_vs_press", rv, 16'h0001);
        bus_rd(9'h150, rv); check_eq("status_after", rv, 16'h00ED);

        // Bus isolation
        mem_addr = 9'h150;
        mem_cmd  = 2'b00;
        #1;
        check_eq("iso_nocmd", rd_bus, 16'hFFFF);
        bus_rd(9'h140, rv); check_eq("iso_sw", rv, 16'hFFFF);
        bus_rd(9'h0FF, rv); check_eq("iso_0ff", rv, 16'hFFFF);
        bus_rd(9'h050, rv); check_eq("iso_alias", rv, 16'hFFFF);
        bus_wr(9'h152, 16'hFFFF);
        bus_rd(9'h150, rv); check_eq("wr152_status", rv, 16'h00ED);
        bus_rd(9'h151, rv); check_eq("wr152_count", rv, 16'h0001);

        // Clear all events, interrupt drops
        bus_wr(9'h150, 16'h00F0);
        bus_rd(9'h150, rv); check_eq("final_status", rv, 16'h000D);
        tick(1);
        check_eq("final_irq", {15'b0, key_irq}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
